npu_sigmoid_fifo: RTL and testbench

Output buffer stage directly downstream of the NPU sigmoid unit. Captures each 16-bit sigmoid result when the scheduler-issued valid, delayed to match the sigmoid unit latency, arrives. Buffers results in a circular FIFO and presents them first-word-fall-through to the consumer (PE feedback path or output FIFO). Gives the scheduler almost-full backpressure and a sticky overflow flag.

---
 rtl/npu_sigmoid_fifo_pkg.sv | 10 +
 rtl/npu_sigmoid_fifo_if.sv | 27 ++
 rtl/npu_sync_ram.sv | 28 ++
 rtl/npu_sigmoid_fifo.sv | 64 ++++++
 tb/tb_npu_sigmoid_fifo.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/npu_sigmoid_fifo_pkg.sv
// npu_sigmoid_fifo_pkg: shared NPU constants (data width, FIFO depth, sigmoid latency) and function-select encodings
package npu_sigmoid_fifo_pkg;
  localparam int NPU_DATA_W      = 16;
  localparam int NPU_FIFO_DEPTH  = 64;
  localparam int NPU_SIG_LATENCY = 1;
  typedef enum logic {
    NPU_FUNC_TANH   = 1'b0,
    NPU_FUNC_LINEAR = 1'b1
  } npu_func_e;
endpackage

// File: rtl/npu_sigmoid_fifo_if.sv
// npu_sigmoid_fifo_if: sigmoid capture / FIFO consumer bundle; slave = FIFO side, master = scheduler+consumer side
interface npu_sigmoid_fifo_if
  import npu_sigmoid_fifo_pkg::*;
#(
  parameter int DEPTH  = NPU_FIFO_DEPTH,
  parameter int DATA_W = NPU_DATA_W
);
  logic                     npu_sched_sigmoid_issue;
  logic [DATA_W-1:0]        npu_sigmoid_dout;
  logic                     npu_sfifo_rd_en;
  logic [DATA_W-1:0]        npu_sfifo_dout;
  logic                     npu_sfifo_empty;
  logic                     npu_sfifo_full;
  logic                     npu_sfifo_almost_full;
  logic [$clog2(DEPTH):0]   npu_sfifo_count;
  logic                     npu_sfifo_overflow;
  modport slave (
    input  npu_sched_sigmoid_issue, npu_sigmoid_dout, npu_sfifo_rd_en,
    output npu_sfifo_dout, npu_sfifo_empty, npu_sfifo_full, npu_sfifo_almost_full,
           npu_sfifo_count, npu_sfifo_overflow
  );
  modport master (
    output npu_sched_sigmoid_issue, npu_sigmoid_dout, npu_sfifo_rd_en,
    input  npu_sfifo_dout, npu_sfifo_empty, npu_sfifo_full, npu_sfifo_almost_full,
           npu_sfifo_count, npu_sfifo_overflow
  );
endinterface

// File: rtl/npu_sync_ram.sv
// npu_sync_ram: DEPTH x DATA_W RAM, one write port, one registered read port with write-through; ports clk, rst (clears read reg), i_we/i_wa/i_wd, i_re/i_ra, o_rd
module npu_sync_ram
  import npu_sigmoid_fifo_pkg::*;
#(
  parameter int DEPTH  = NPU_FIFO_DEPTH,
  parameter int DATA_W = NPU_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_wa,
  input  logic [DATA_W-1:0]        i_wd,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_ra,
  output logic [DATA_W-1:0]        o_rd
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd;
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wa] <= i_wd;
  end
  // Write-through so a word written into the slot being read is visible one edge later.
  always_ff @(posedge clk) begin
    if (rst) r_rd <= '0;
    else if (i_re) r_rd <= (i_we && i_wa == i_ra) ? i_wd : r_mem[i_ra];
  end
  assign o_rd = r_rd;
endmodule

// File: rtl/npu_sigmoid_fifo.sv
// npu_sigmoid_fifo: latency-aligned capture of sigmoid results into a FWFT circular FIFO; ports CLK, npu_rst, bus (slave: issue/data/rd_en in, dout/flags/count out)
module npu_sigmoid_fifo
  import npu_sigmoid_fifo_pkg::*;
#(
  parameter int DEPTH       = NPU_FIFO_DEPTH,
  parameter int DATA_W      = NPU_DATA_W,
  parameter int SIG_LATENCY = NPU_SIG_LATENCY,
  parameter int AF_MARGIN   = 2
) (
  input logic               CLK,
  input logic               npu_rst,
  npu_sigmoid_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [SIG_LATENCY-1:0] r_issue;
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr, w_rd_next;
  logic [AW:0]            r_count, w_count_next;
  logic                   r_empty, r_full, r_af, r_ovf;
  logic                   w_wr_req, w_rd_fire, w_wr_en;
  always_comb begin
    w_wr_req     = r_issue[SIG_LATENCY-1];
    w_rd_fire    = bus.npu_sfifo_rd_en && !r_empty;
    w_wr_en      = w_wr_req && (!r_full || w_rd_fire);
    w_rd_next    = r_rd_ptr + AW'(w_rd_fire);
    w_count_next = r_count + (AW+1)'(w_wr_en) - (AW+1)'(w_rd_fire);
  end
  always_ff @(posedge CLK) begin
    if (npu_rst) begin
      r_issue  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_af     <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_issue  <= SIG_LATENCY'({r_issue, bus.npu_sched_sigmoid_issue});
      r_wr_ptr <= r_wr_ptr + AW'(w_wr_en);
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_empty  <= w_count_next == '0;
      r_full   <= w_count_next == (AW+1)'(DEPTH);
      r_af     <= w_count_next >= (AW+1)'(DEPTH - AF_MARGIN);
      r_ovf    <= r_ovf | (w_wr_req & !w_wr_en);
    end
  end
  // Read port tracks the post-update head; it holds its last value once the FIFO drains.
  npu_sync_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_ram (
    .clk  (CLK),
    .rst  (npu_rst),
    .i_we (w_wr_en),
    .i_wa (r_wr_ptr),
    .i_wd (bus.npu_sigmoid_dout),
    .i_re (w_count_next != '0),
    .i_ra (w_rd_next),
    .o_rd (bus.npu_sfifo_dout)
  );
  assign bus.npu_sfifo_empty       = r_empty;
  assign bus.npu_sfifo_full        = r_full;
  assign bus.npu_sfifo_almost_full = r_af;
  assign bus.npu_sfifo_count       = r_count;
  assign bus.npu_sfifo_overflow    = r_ovf;
endmodule

// File: tb/tb_npu_sigmoid_fifo.sv
// tb_npu_sigmoid_fifo: table vectors, directed corner sequences and random traffic against a queue-based model
module tb_npu_sigmoid_fifo;
  localparam int DEPTH = 64;
  localparam int LAT   = 1;
  localparam int AFM   = 2;
  logic CLK = 1'b0;
  logic npu_rst = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  npu_sigmoid_fifo_if #(.DEPTH(DEPTH), .DATA_W(16)) bus ();
  npu_sigmoid_fifo #(.DEPTH(DEPTH), .DATA_W(16), .SIG_LATENCY(LAT), .AF_MARGIN(AFM)) dut (
    .CLK     (CLK),
    .npu_rst (npu_rst),
    .bus     (bus)
  );
  always #5 CLK = ~CLK;
  logic [15:0] m_q[$];
  bit          m_pipe[$];
  bit          m_ovf;
  logic [15:0] m_dout;
  typedef struct {
    bit iss; logic [15:0] d; bit rd;
    int cnt; bit emp; logic [15:0] dout; bit chk_dout;
  } vec_t;
  vec_t tbl[9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_q.delete();
    m_pipe.delete();
    for (int i = 0; i < LAT; i++) m_pipe.push_back(1'b0);
    m_ovf = 1'b0;
    m_dout = '0;
  endtask
  task automatic model_step(input bit iss, input logic [15:0] d, input bit rd);
    bit wr, rd_ok;
    if (npu_rst) begin
      model_reset();
      return;
    end
    wr = m_pipe.pop_front();
    m_pipe.push_back(iss);
    rd_ok = rd && m_q.size() > 0;
    if (wr && m_q.size() == DEPTH && !rd_ok) m_ovf = 1'b1;
    if (rd_ok) void'(m_q.pop_front());
    if (wr && m_q.size() < DEPTH) m_q.push_back(d);
    if (m_q.size() > 0) m_dout = m_q[0];
  endtask
  task automatic cyc(input bit iss, input logic [15:0] d, input bit rd);
    bus.npu_sched_sigmoid_issue = iss;
    bus.npu_sigmoid_dout = d;
    bus.npu_sfifo_rd_en = rd;
    @(posedge CLK);
    model_step(iss, d, rd);
    #1;
  endtask
  task automatic chk_model();
    chk("model count", 32'(bus.npu_sfifo_count), 32'(m_q.size()));
    chk("model empty", 32'(bus.npu_sfifo_empty), 32'(m_q.size() == 0));
    chk("model full", 32'(bus.npu_sfifo_full), 32'(m_q.size() == DEPTH));
    chk("model almost_full", 32'(bus.npu_sfifo_almost_full), 32'(m_q.size() >= DEPTH - AFM));
    chk("model overflow", 32'(bus.npu_sfifo_overflow), 32'(m_ovf));
    if (m_q.size() > 0) chk("model dout", 32'(bus.npu_sfifo_dout), 32'(m_dout));
  endtask
  task automatic do_reset();
    npu_rst = 1'b1;
    cyc(1'b0, 16'h0, 1'b0);
    npu_rst = 1'b0;
  endtask
  initial begin
    tbl[0] = '{1, 16'h0000, 0, 0, 1, 16'h0000, 0};
    tbl[1] = '{0, 16'h0080, 0, 1, 0, 16'h0080, 1};
    tbl[2] = '{0, 16'h1234, 1, 0, 1, 16'h0000, 0};
    tbl[3] = '{1, 16'h0000, 1, 0, 1, 16'h0000, 0};
    tbl[4] = '{0, 16'hFF80, 1, 1, 0, 16'hFF80, 1};
    tbl[5] = '{1, 16'hAAAA, 0, 1, 0, 16'hFF80, 1};
    tbl[6] = '{0, 16'h5555, 0, 2, 0, 16'hFF80, 1};
    tbl[7] = '{0, 16'h0000, 1, 1, 0, 16'h5555, 1};
    tbl[8] = '{0, 16'h0000, 1, 0, 1, 16'h0000, 0};
    model_reset();
    bus.npu_sched_sigmoid_issue = 1'b0;
    bus.npu_sigmoid_dout = '0;
    bus.npu_sfifo_rd_en = 1'b0;
    do_reset();
    chk("reset count", 32'(bus.npu_sfifo_count), 32'd0);
    chk("reset empty", 32'(bus.npu_sfifo_empty), 32'd1);
    chk("reset full", 32'(bus.npu_sfifo_full), 32'd0);
    chk("reset almost_full", 32'(bus.npu_sfifo_almost_full), 32'd0);
    chk("reset overflow", 32'(bus.npu_sfifo_overflow), 32'd0);
    chk("reset dout", 32'(bus.npu_sfifo_dout), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 16'h0, 1'b1);
      chk("idle rd count", 32'(bus.npu_sfifo_count), 32'd0);
      chk("idle rd overflow", 32'(bus.npu_sfifo_overflow), 32'd0);
    end
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].iss, tbl[i].d, tbl[i].rd);
      chk($sformatf("tbl%0d count", i), 32'(bus.npu_sfifo_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d empty", i), 32'(bus.npu_sfifo_empty), 32'(tbl[i].emp));
      if (tbl[i].chk_dout) chk($sformatf("tbl%0d dout", i), 32'(bus.npu_sfifo_dout), 32'(tbl[i].dout));
    end
    // Burst past full: issue i writes data i on the following cycle.
    for (int i = 0; i <= 65; i++) begin
      cyc(i < 65, 16'(i - 1), 1'b0);
      chk("burst count", 32'(bus.npu_sfifo_count), 32'(i > 64 ? 64 : i));
      chk("burst almost_full", 32'(bus.npu_sfifo_almost_full), 32'(i >= 62));
      chk("burst full", 32'(bus.npu_sfifo_full), 32'(i >= 64));
      chk("burst overflow", 32'(bus.npu_sfifo_overflow), 32'(i >= 65));
    end
    for (int j = 0; j < 64; j++) begin
      chk("burst readback", 32'(bus.npu_sfifo_dout), 32'(j));
      cyc(1'b0, 16'h0, 1'b1);
    end
    chk("drained empty", 32'(bus.npu_sfifo_empty), 32'd1);
    chk("sticky overflow", 32'(bus.npu_sfifo_overflow), 32'd1);
    do_reset();
    chk("overflow cleared", 32'(bus.npu_sfifo_overflow), 32'd0);
    for (int i = 0; i <= 64; i++) cyc(i < 64, 16'(i - 1), 1'b0);
    for (int k = 0; k <= 100; k++) begin
      cyc(k < 100, 16'(64 + k - 1), k >= 1);
      chk("full rw count", 32'(bus.npu_sfifo_count), 32'd64);
      chk("full rw overflow", 32'(bus.npu_sfifo_overflow), 32'd0);
      chk("full rw dout", 32'(bus.npu_sfifo_dout), 32'(k));
    end
    for (int j = 0; j < 64; j++) begin
      cyc(1'b0, 16'h0, 1'b1);
      chk_model();
    end
    do_reset();
    for (int i = 0; i <= 10; i++) cyc(i < 10, 16'(16'h100 + i), 1'b0);
    chk("ten stored", 32'(bus.npu_sfifo_count), 32'd10);
    cyc(1'b1, 16'h0, 1'b0);
    npu_rst = 1'b1;
    cyc(1'b0, 16'hDEAD, 1'b0);
    npu_rst = 1'b0;
    chk("flight rst count", 32'(bus.npu_sfifo_count), 32'd0);
    chk("flight rst empty", 32'(bus.npu_sfifo_empty), 32'd1);
    chk("flight rst overflow", 32'(bus.npu_sfifo_overflow), 32'd0);
    cyc(1'b0, 16'hBEEF, 1'b0);
    chk("flight dropped", 32'(bus.npu_sfifo_count), 32'd0);
    for (int c = 0; c < 3000; c++) begin
      int pi, pr;
      pi = (c / 500) % 2 == 0 ? 80 : 40;
      pr = (c / 500) % 2 == 0 ? 40 : 80;
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 99) < pi, 16'($urandom), $urandom_range(0, 99) < pr);
      end
      chk_model();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
